// File: rtl/burst_mem_responder.sv
// rtl/burst_mem_responder.sv - fixed-latency 4-beat line read/write memory responder
module burst_mem_responder #(
    parameter int LINES   = 16,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [63:0] mem_wdata,
    output logic [63:0] mem_rdata,
    output logic        mem_resp,
    output logic        proto_err,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);
    localparam int LW = $clog2(LINES);
    localparam logic [3:0] WAIT_INIT = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

    state_t        state;
    logic          is_write;
    logic [LW-1:0] line;
    logic [1:0]    beat;
    logic [3:0]    wait_cnt;
    logic          conflict_q;
    logic [63:0]   mem [LINES*4];

    logic [LW-1:0] addr_line;
    logic          op_held;
    logic          mem_we;
    logic          unused_addr_bits;

    assign addr_line        = mem_address[5+LW-1:5];
    assign unused_addr_bits = ^{mem_address[31:5+LW], mem_address[4:0]};
    assign op_held          = is_write ? mem_write : mem_read;
    // A beat is committed only while the initiator still holds the write request.
    assign mem_we           = rst && (state == BURST) && is_write && mem_write;

    // Storage is kept out of the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[{line, beat}] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            is_write   <= 1'b0;
            line       <= '0;
            beat       <= 2'd0;
            wait_cnt   <= 4'd0;
            conflict_q <= 1'b0;
            mem_resp   <= 1'b0;
            mem_rdata  <= 64'd0;
            proto_err  <= 1'b0;
            rd_count   <= 16'd0;
            wr_count   <= 16'd0;
        end else begin
            proto_err  <= 1'b0;
            conflict_q <= (state == IDLE) && mem_read && mem_write;
            case (state)
                IDLE: begin
                    if (mem_read ^ mem_write) begin
                        is_write <= mem_write;
                        line     <= addr_line;
                        beat     <= 2'd0;
                        wait_cnt <= WAIT_INIT;
                        if (LATENCY == 1) begin
                            state     <= BURST;
                            mem_resp  <= 1'b1;
                            mem_rdata <= mem_read ? mem[{addr_line, 2'd0}] : 64'd0;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (mem_read && mem_write && !conflict_q) begin
                        // One pulse per conflict episode, not one per held cycle.
                        proto_err <= 1'b1;
                    end
                end
                WAIT: begin
                    if (!op_held) begin
                        state     <= IDLE;
                        proto_err <= 1'b1;
                    end else if (wait_cnt == 4'd0) begin
                        state     <= BURST;
                        mem_resp  <= 1'b1;
                        mem_rdata <= is_write ? 64'd0 : mem[{line, 2'd0}];
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                BURST: begin
                    if (!op_held) begin
                        state     <= IDLE;
                        proto_err <= 1'b1;
                        mem_resp  <= 1'b0;
                        mem_rdata <= 64'd0;
                    end else if (beat == 2'd3) begin
                        state     <= DONE;
                        mem_resp  <= 1'b0;
                        mem_rdata <= 64'd0;
                        if (is_write) wr_count <= wr_count + 16'd1;
                        else          rd_count <= rd_count + 16'd1;
                    end else begin
                        beat      <= beat + 2'd1;
                        mem_rdata <= is_write ? 64'd0 : mem[{line, beat + 2'd1}];
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_burst_mem_responder.sv
// tb/tb_burst_mem_responder.sv - directed self-checking bench for burst_mem_responder
module tb_burst_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_resp;
    logic        proto_err;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    int checks   = 0;
    int failures = 0;
    logic [63:0] mdl [16][4];
    logic [63:0] wbuf [4];

    burst_mem_responder #(.LINES(16), .LATENCY(4)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp), .proto_err(proto_err), .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_resp", mem_resp, 0);
            step();
        end
    endtask

    // Cycle 0 is the request cycle; drop < 4 releases the request during beat `drop`.
    task automatic burst(input bit wr, input logic [31:0] addr, input int drop);
        int ln   = int'(addr[8:5]);
        int last = (drop < 4) ? 4 + drop : 7;
        int kept = (drop < 4) ? drop : 4;
        mem_read    = !wr;
        mem_write   = wr;
        mem_address = addr;
        mem_wdata   = 64'd0;
        for (int k = 0; k < 8; k++) begin
            int idx = (k >= 4) ? k - 4 : 0;
            if (k == 1) mem_address = addr ^ 32'h0000_01E0;
            if (k >= 4) mem_wdata = wr ? wbuf[idx] : 64'd0;
            if (k == 4 + drop) begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
            @(negedge clk);
            check("resp", mem_resp, (k >= 4 && k <= last) ? 64'd1 : 64'd0);
            check("rdata", mem_rdata, (!wr && k >= 4 && k <= last) ? mdl[ln][idx] : 64'd0);
            check("proto_err", proto_err, (k == 5 + drop) ? 64'd1 : 64'd0);
            step();
        end
        if (wr) for (int i = 0; i < kept; i++) mdl[ln][i] = wbuf[i];
    endtask

    initial begin
        bit seen;
        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wdata = '0;
        repeat (2) step();
        @(negedge clk);
        check("rst_resp", mem_resp, 0);
        check("rst_rdata", mem_rdata, 0);
        check("rst_proto", proto_err, 0);
        check("rst_rd", rd_count, 0);
        check("rst_wr", wr_count, 0);
        rst = 1'b1;
        step();

        wbuf = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        burst(1'b1, 32'h0000_0040, 4);
        idle(2);
        burst(1'b0, 32'h0000_0040, 4);
        idle(1);
        check("wr_count_1", wr_count, 1);
        check("rd_count_1", rd_count, 1);

        wbuf = '{default: 64'hAAAA_AAAA_AAAA_AAAA};
        burst(1'b1, 32'h0000_0200, 4);
        idle(1);
        burst(1'b0, 32'h0000_0000, 4);
        idle(1);

        wbuf = '{64'h5555_5555_5555_5555, 64'h5A5A_5A5A_5A5A_5A5A,
                 64'h5B5B_5B5B_5B5B_5B5B, 64'h5C5C_5C5C_5C5C_5C5C};
        burst(1'b1, 32'h0000_0080, 4);
        idle(1);
        wbuf = '{64'h6666_6666_6666_6666, 64'h7777_7777_7777_7777,
                 64'h8888_8888_8888_8888, 64'h9999_9999_9999_9999};
        burst(1'b1, 32'h0000_0080, 2);
        idle(1);
        check("abort_wr_count", wr_count, 3);
        burst(1'b0, 32'h0000_0080, 4);
        idle(1);
        check("rd_count_3", rd_count, 3);

        mem_read = 1'b1; mem_write = 1'b1; mem_address = 32'h0000_0040;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_resp) seen = 1'b1;
            if (k == 1) check("conflict_pulse", proto_err, 1);
            if (k == 2) check("conflict_pulse_end", proto_err, 0);
            step();
        end
        check("conflict_no_resp", seen, 0);
        idle(1);
        check("conflict_rd", rd_count, 3);
        check("conflict_wr", wr_count, 3);

        burst(1'b0, 32'h0000_0040, 4);
        mem_read = 1'b1; mem_address = 32'h0000_0080;
        @(negedge clk);
        check("done_resp", mem_resp, 0);
        step();
        burst(1'b0, 32'h0000_0080, 4);
        idle(1);
        check("b2b_rd_count", rd_count, 5);

        mem_read = 1'b1; mem_address = 32'h0000_0040;
        repeat (6) step();
        @(negedge clk);
        check("pre_rst_beat2", mem_resp, 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        mem_read = 1'b0;
        check("midrst_resp", mem_resp, 0);
        check("midrst_proto", proto_err, 0);
        check("midrst_rd", rd_count, 0);
        check("midrst_wr", wr_count, 0);
        burst(1'b0, 32'h0000_0040, 4);
        idle(1);
        check("post_rst_rd", rd_count, 1);
        check("post_rst_wr", wr_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/burst_mem_responder.md
BURST_MEM_RESPONDER -- requirements
Module: burst_mem_responder

Interface
REQ-001 SHALL have parameter LINES, default 16, meaning number of 32-byte lines stored (power of 2, >=2).
REQ-002 SHALL have parameter LATENCY, default 4, meaning cycles from accepted request to first response beat (1..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port mem_read  input  1  line read request; held high by the initiator until its 4th beat.
REQ-006 SHALL have port mem_write  input  1  line write request; held high by the initiator until its 4th beat.
REQ-007 SHALL have port mem_address  input  32  line address; bits [4:0] ignored.
REQ-008 SHALL have port mem_wdata  input  64  write beat data.
REQ-009 SHALL have port mem_rdata  output  64  read beat data.
REQ-010 SHALL have port mem_resp  output  1  per-beat response strobe.
REQ-011 SHALL have port proto_err  output  1  one-cycle pulse on a protocol violation.
REQ-012 SHALL have ports rd_count and wr_count  output  16 each  completed read and write bursts.

Function
REQ-013 Storage SHALL be LINES x 4 beats x 64 bits. Line index = mem_address[5+log2(LINES)-1:5], wrapping modulo LINES.
REQ-014 Beat i (0..3) SHALL map to bytes [8i+7:8i] of the line, sent in ascending order.
REQ-015 The FSM SHALL have states IDLE, WAIT, BURST and DONE.
REQ-016 In IDLE, exactly one of mem_read/mem_write high in cycle c SHALL latch the address and type and enter WAIT.
REQ-017 The first mem_resp SHALL occur in cycle c+LATENCY, in BURST.
REQ-018 mem_resp SHALL stay high for exactly 4 consecutive cycles (beats 0..3), then the FSM SHALL enter DONE.
REQ-019 Read beat i SHALL drive mem_rdata = stored beat i in the same cycle mem_resp is high.
REQ-020 Outside read beats, mem_rdata SHALL be 0.
REQ-021 On write beat i, mem_wdata SHALL be written to beat i at the clock edge ending that cycle.
REQ-022 DONE SHALL last exactly 1 cycle with mem_resp low and requests ignored, then return to IDLE.
REQ-023 On entering DONE, rd_count or wr_count SHALL increment by 1, wrapping 0xFFFF->0x0000.
REQ-024 mem_read and mem_write both high in IDLE: no transaction, proto_err pulses the next cycle, FSM stays IDLE.
REQ-025 The requested op dropping low in WAIT or BURST SHALL abort: proto_err pulses the next cycle, FSM returns to IDLE, no counter increment.
REQ-026 On abort, write beats already taken SHALL remain committed.
REQ-027 mem_address changes after acceptance SHALL be ignored until the next IDLE acceptance.
REQ-028 mem_resp SHALL never be high outside BURST.

Reset
REQ-029 rst low at a clock edge SHALL force IDLE and set mem_resp=0, mem_rdata=0, proto_err=0, rd_count=0, wr_count=0.
REQ-030 Reset SHALL NOT clear storage contents.
REQ-031 Reset mid-burst SHALL abandon the burst with no proto_err and no counter increment; committed write beats remain.

Verification
REQ-032 Write then read, LATENCY=4: write 0x0000_0040 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 (request cycle 0; resp cycles 4-7), then read same address -> mem_rdata returns the same 4 values in order in cycles 4-7 after the read request; wr_count=1, rd_count=1.
REQ-033 Alias, LINES=16: write 0x0000_0200 with beats 0xA..A, then read 0x0000_0000 -> returns 0xA..A beats.
REQ-034 Abort: start a write to 0x80, drop mem_write after beat 1 -> proto_err=1 for one cycle, FSM in IDLE; a read of 0x80 returns beats 0-1 new and beats 2-3 old; wr_count unchanged.
REQ-035 Conflict: mem_read=mem_write=1 in IDLE -> proto_err pulse, no mem_resp for 20 cycles while both held.
REQ-036 Reset during BURST beat 2 of a read -> next cycle mem_resp=0, counters=0; a new read immediately after reset completes normally.
REQ-037 Back-to-back: initiator re-asserts mem_read the cycle after beat 3 -> request ignored during DONE, accepted the following cycle, first beat exactly LATENCY cycles later.
